// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset/initialisation sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_INIT,
        ST_GAP,
        ST_RUN,
        ST_FAULT
    } seq_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int DEF_CNT_W = cnt_width(65536);
    localparam int DEF_FC_W  = cnt_width(4 - 1);
    localparam int DEF_RC_W  = cnt_width(3);

endpackage

// File: rtl/reset_sequencer_if.sv
// Per-channel reset/init nets and status between the sequencer and its channels.
interface reset_sequencer_if #(
    parameter int CHANNELS = 4,
    parameter int FC_W     = reset_seq_pkg::DEF_FC_W,
    parameter int RC_W     = reset_seq_pkg::DEF_RC_W
);
    logic [CHANNELS-1:0] rst_request;
    logic [CHANNELS-1:0] init_done;
    logic [CHANNELS-1:0] sync_rst_out;
    logic [CHANNELS-1:0] clk_en_out;
    logic [CHANNELS-1:0] init_out;
    logic                seq_busy;
    logic                fault;
    logic [FC_W-1:0]     fault_channel;
    logic [RC_W-1:0]     retry_count;

    modport master (
        input  rst_request, init_done,
        output sync_rst_out, clk_en_out, init_out, seq_busy,
               fault, fault_channel, retry_count
    );

    modport slave (
        output rst_request, init_done,
        input  sync_rst_out, clk_en_out, init_out, seq_busy,
               fault, fault_channel, retry_count
    );
endinterface

// File: rtl/reset_seq_timer.sv
// Loadable down-counter, saturating at zero; done flags the terminal count.
module reset_seq_timer #(
    parameter int               WIDTH       = reset_seq_pkg::DEF_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             sys_clk,
    input  logic             async_rst_in,
    input  logic             clk_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge sys_clk or posedge async_rst_in) begin
        if (async_rst_in) begin
            count <= RESET_VALUE;
        end else if (clk_en) begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/reset_sequencer.sv
// Holds all channels in reset, then releases and initialises them in index
// order with per-stage timeout, bounded full-sequence retries and fault latch.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int HOLDCYCLES    = 16,
    parameter int STAGEGAP      = 64,
    parameter int TIMEOUTCYCLES = 65536,
    parameter int MAXRETRIES    = 3
) (
    input  logic              sys_clk,
    input  logic              async_rst_in,
    input  logic              clk_en,
    reset_sequencer_if.master bus
);
    // state  | meaning
    // ASSERT | all channels in reset, hold timer running
    // INIT   | channel `stage` released with init_out high, waiting for init_done
    // GAP    | spacing between an acknowledge and the next channel release
    // RUN    | every channel released, seq_busy low
    // FAULT  | retries exhausted, channels in reset, fault latched

    localparam int CNT_W = cnt_width(max3(HOLDCYCLES, STAGEGAP, TIMEOUTCYCLES));
    localparam int FC_W  = cnt_width(CHANNELS - 1);
    localparam int RC_W  = cnt_width(MAXRETRIES);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDCYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((STAGEGAP > 0) ? STAGEGAP - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUTCYCLES - 1);
    localparam logic [FC_W-1:0]  LAST_CH   = FC_W'(CHANNELS - 1);
    localparam logic [RC_W-1:0]  MAX_RETRY = RC_W'(MAXRETRIES);

    seq_state_e       state;
    logic [FC_W-1:0]  stage;
    logic [FC_W-1:0]  next_stage;
    logic             pending;
    logic             req_now;
    logic             ack;
    logic             last;
    logic             tmr_done;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;

    assign req_now    = pending | (|bus.rst_request);
    assign ack        = bus.init_done[stage];
    assign last       = (stage == LAST_CH);
    assign next_stage = stage + 1'b1;

    // Reload the shared timer on the same edge the FSM enters a timed state.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = HOLD_LOAD;
        if (req_now) begin
            tmr_load = 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (tmr_done) begin
                        tmr_load  = 1'b1;
                        tmr_value = TMO_LOAD;
                    end
                end
                ST_INIT: begin
                    if (ack) begin
                        if (!last) begin
                            tmr_load  = 1'b1;
                            tmr_value = (STAGEGAP == 0) ? TMO_LOAD : GAP_LOAD;
                        end
                    end else if (tmr_done) begin
                        tmr_load = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        tmr_load  = 1'b1;
                        tmr_value = TMO_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    reset_seq_timer #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (HOLD_LOAD)
    ) u_timer (
        .sys_clk      (sys_clk),
        .async_rst_in (async_rst_in),
        .clk_en       (clk_en),
        .load         (tmr_load),
        .load_value   (tmr_value),
        .done         (tmr_done)
    );

    always_ff @(posedge sys_clk or posedge async_rst_in) begin
        if (async_rst_in) begin
            state             <= ST_ASSERT;
            stage             <= '0;
            pending           <= 1'b0;
            bus.sync_rst_out  <= '1;
            bus.clk_en_out    <= '0;
            bus.init_out      <= '0;
            bus.seq_busy      <= 1'b1;
            bus.fault         <= 1'b0;
            bus.fault_channel <= '0;
            bus.retry_count   <= '0;
        end else begin
            // Every enabled edge acts on req_now by entering ASSERT, so capture
            // only needs to persist across disabled edges.
            pending <= req_now & ~clk_en;
            if (clk_en) begin
                if (req_now) begin
                    if (state == ST_FAULT) begin
                        bus.fault         <= 1'b0;
                        bus.fault_channel <= '0;
                        bus.retry_count   <= '0;
                    end
                    state            <= ST_ASSERT;
                    stage            <= '0;
                    bus.sync_rst_out <= '1;
                    bus.clk_en_out   <= '0;
                    bus.init_out     <= '0;
                    bus.seq_busy     <= 1'b1;
                end else begin
                    case (state)
                        ST_ASSERT: begin
                            if (tmr_done) begin
                                state               <= ST_INIT;
                                stage               <= '0;
                                bus.sync_rst_out[0] <= 1'b0;
                                bus.clk_en_out[0]   <= 1'b1;
                                bus.init_out[0]     <= 1'b1;
                            end
                        end
                        ST_INIT: begin
                            if (ack) begin
                                bus.init_out[stage] <= 1'b0;
                                if (last) begin
                                    state           <= ST_RUN;
                                    bus.seq_busy    <= 1'b0;
                                    bus.retry_count <= '0;
                                end else if (STAGEGAP == 0) begin
                                    state                        <= ST_INIT;
                                    stage                        <= next_stage;
                                    bus.sync_rst_out[next_stage] <= 1'b0;
                                    bus.clk_en_out[next_stage]   <= 1'b1;
                                    bus.init_out[next_stage]     <= 1'b1;
                                end else begin
                                    state <= ST_GAP;
                                end
                            end else if (tmr_done) begin
                                bus.sync_rst_out <= '1;
                                bus.clk_en_out   <= '0;
                                bus.init_out     <= '0;
                                if (bus.retry_count < MAX_RETRY) begin
                                    state           <= ST_ASSERT;
                                    stage           <= '0;
                                    bus.retry_count <= bus.retry_count + 1'b1;
                                end else begin
                                    state             <= ST_FAULT;
                                    bus.fault         <= 1'b1;
                                    bus.fault_channel <= stage;
                                end
                            end
                        end
                        ST_GAP: begin
                            if (tmr_done) begin
                                state                        <= ST_INIT;
                                stage                        <= next_stage;
                                bus.sync_rst_out[next_stage] <= 1'b0;
                                bus.clk_en_out[next_stage]   <= 1'b1;
                                bus.init_out[next_stage]     <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: 3 channels, hold 4, gap 2, timeout 8, 2 retries.
module tb_reset_sequencer;
    logic sys_clk      = 1'b0;
    logic async_rst_in = 1'b0;
    logic clk_en       = 1'b1;
    int   n_checks     = 0;
    int   n_fail       = 0;

    reset_sequencer_if #(.CHANNELS(3), .FC_W(2), .RC_W(2)) bus ();

    reset_sequencer #(
        .CHANNELS      (3),
        .HOLDCYCLES    (4),
        .STAGEGAP      (2),
        .TIMEOUTCYCLES (8),
        .MAXRETRIES    (2)
    ) dut (
        .sys_clk      (sys_clk),
        .async_rst_in (async_rst_in),
        .clk_en       (clk_en),
        .bus          (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // {sync_rst_out, clk_en_out, init_out, seq_busy}
    logic [9:0] vec;
    assign vec = {bus.sync_rst_out, bus.clk_en_out, bus.init_out, bus.seq_busy};

    localparam logic [9:0] V_RESET = 10'b111_000_000_1;
    localparam logic [9:0] V_INIT0 = 10'b110_001_001_1;
    localparam logic [9:0] V_GAP0  = 10'b110_001_000_1;
    localparam logic [9:0] V_INIT1 = 10'b100_011_010_1;
    localparam logic [9:0] V_GAP1  = 10'b100_011_000_1;
    localparam logic [9:0] V_INIT2 = 10'b000_111_100_1;
    localparam logic [9:0] V_RUN   = 10'b000_111_000_0;

    // index 0: before the first edge after reset release; index n: after edge n
    localparam logic [9:0] REL_VEC [0:11] = '{
        V_RESET, V_RESET, V_RESET, V_RESET,
        V_INIT0, V_GAP0, V_GAP0,
        V_INIT1, V_GAP1, V_GAP1,
        V_INIT2, V_RUN
    };

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset(input logic [2:0] done_val);
        async_rst_in    = 1'b1;
        clk_en          = 1'b1;
        bus.rst_request = '0;
        bus.init_done   = done_val;
        step();
        step();
        async_rst_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.rst_request = '0;
        bus.init_done   = '0;
        #1 async_rst_in = 1'b1;
        #1;
        n_checks++;
        if (vec !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_async vec got %b want %b", vec, V_RESET);
        end
        step();
        step();
        n_checks++;
        if (vec !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_held vec got %b want %b", vec, V_RESET);
        end
        n_checks++;
        if ({bus.fault, bus.fault_channel, bus.retry_count} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_status got %b want %b",
                     {bus.fault, bus.fault_channel, bus.retry_count}, 5'b0);
        end
    endtask

    task automatic test_release();
        apply_reset(3'b111);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (vec !== REL_VEC[i]) begin
                n_fail++;
                $display("FAIL release[%0d] vec got %b want %b", i, vec, REL_VEC[i]);
            end
            step();
        end
        n_checks++;
        if (vec !== V_RUN) begin
            n_fail++;
            $display("FAIL release_run vec got %b want %b", vec, V_RUN);
        end
    endtask

    task automatic test_clk_en();
        logic [9:0] exp;
        apply_reset(3'b111);
        for (int i = 1; i <= 10; i++) begin
            clk_en = (i % 2 == 0);
            step();
            exp = (i < 8) ? V_RESET : (i < 10) ? V_INIT0 : V_GAP0;
            n_checks++;
            if (vec !== exp) begin
                n_fail++;
                $display("FAIL clk_en_gate[%0d] vec got %b want %b", i, vec, exp);
            end
        end
        clk_en = 1'b1;
    endtask

    task automatic test_timeout();
        apply_reset(3'b001);
        for (int r = 1; r <= 3; r++) begin
            repeat (14) step();
            n_checks++;
            if (vec !== V_INIT1 || bus.fault !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d] vec got %b want %b fault %b", r, vec, V_INIT1, bus.fault);
            end
            step();
            n_checks++;
            if (vec !== V_RESET) begin
                n_fail++;
                $display("FAIL timeout_vec[%0d] vec got %b want %b", r, vec, V_RESET);
            end
            n_checks++;
            if (bus.retry_count !== ((r < 3) ? 2'(r) : 2'd2)) begin
                n_fail++;
                $display("FAIL timeout_retry[%0d] got %0d want %0d", r, bus.retry_count, (r < 3) ? r : 2);
            end
            n_checks++;
            if ({bus.fault, bus.fault_channel} !== ((r < 3) ? 3'b0_00 : 3'b1_01)) begin
                n_fail++;
                $display("FAIL timeout_fault[%0d] got %b want %b", r,
                         {bus.fault, bus.fault_channel}, (r < 3) ? 3'b0_00 : 3'b1_01);
            end
        end
        repeat (20) step();
        n_checks++;
        if (bus.fault !== 1'b1 || vec !== V_RESET) begin
            n_fail++;
            $display("FAIL fault_hold fault got %b want 1 vec got %b want %b", bus.fault, vec, V_RESET);
        end
        bus.init_done   = 3'b111;
        bus.rst_request = 3'b001;
        step();
        bus.rst_request = '0;
        n_checks++;
        if ({bus.fault, bus.fault_channel, bus.retry_count} !== 5'b0 || vec !== V_RESET) begin
            n_fail++;
            $display("FAIL fault_exit status got %b want 00000 vec got %b want %b",
                     {bus.fault, bus.fault_channel, bus.retry_count}, vec, V_RESET);
        end
        repeat (11) step();
        n_checks++;
        if (vec !== V_RUN) begin
            n_fail++;
            $display("FAIL fault_resequence vec got %b want %b", vec, V_RUN);
        end
    endtask

    task automatic test_request_run();
        bus.rst_request = 3'b100;
        step();
        bus.rst_request = '0;
        n_checks++;
        if (vec !== V_RESET) begin
            n_fail++;
            $display("FAIL req_run_edge vec got %b want %b", vec, V_RESET);
        end
        repeat (3) step();
        n_checks++;
        if (vec !== V_RESET) begin
            n_fail++;
            $display("FAIL req_run_hold vec got %b want %b", vec, V_RESET);
        end
        step();
        n_checks++;
        if (vec !== V_INIT0) begin
            n_fail++;
            $display("FAIL req_run_init0 vec got %b want %b", vec, V_INIT0);
        end
        repeat (7) step();
        n_checks++;
        if (vec !== V_RUN) begin
            n_fail++;
            $display("FAIL req_run_done vec got %b want %b", vec, V_RUN);
        end
        repeat (5) step();
        n_checks++;
        if (vec !== V_RUN) begin
            n_fail++;
            $display("FAIL req_run_stable vec got %b want %b", vec, V_RUN);
        end
    endtask

    task automatic test_request_disabled();
        clk_en = 1'b0;
        step();
        bus.rst_request = 3'b010;
        step();
        bus.rst_request = '0;
        step();
        step();
        n_checks++;
        if (vec !== V_RUN) begin
            n_fail++;
            $display("FAIL req_dis_hold vec got %b want %b", vec, V_RUN);
        end
        clk_en = 1'b1;
        step();
        n_checks++;
        if (vec !== V_RESET) begin
            n_fail++;
            $display("FAIL req_dis_restart vec got %b want %b", vec, V_RESET);
        end
        repeat (11) step();
        n_checks++;
        if (vec !== V_RUN) begin
            n_fail++;
            $display("FAIL req_dis_resequence vec got %b want %b", vec, V_RUN);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset(3'b001);
        repeat (15) step();
        n_checks++;
        if (bus.retry_count !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_first_timeout retry got %0d want 1", bus.retry_count);
        end
        repeat (7) step();
        n_checks++;
        if (vec !== V_INIT1) begin
            n_fail++;
            $display("FAIL simul_init1 vec got %b want %b", vec, V_INIT1);
        end
        bus.init_done   = 3'b011;
        bus.rst_request = 3'b010;
        step();
        bus.rst_request = '0;
        n_checks++;
        if (vec !== V_RESET || bus.retry_count !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_req_wins vec got %b want %b retry got %0d want 1",
                     vec, V_RESET, bus.retry_count);
        end
        bus.init_done = 3'b111;
        repeat (11) step();
        n_checks++;
        if (vec !== V_RUN || bus.retry_count !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_run_clear vec got %b want %b retry got %0d want 0",
                     vec, V_RUN, bus.retry_count);
        end
        apply_reset(3'b111);
        repeat (5) step();
        n_checks++;
        if (vec !== V_GAP0) begin
            n_fail++;
            $display("FAIL gap_reached vec got %b want %b", vec, V_GAP0);
        end
        #2 async_rst_in = 1'b1;
        #1;
        n_checks++;
        if (vec !== V_RESET || {bus.fault, bus.fault_channel, bus.retry_count} !== 5'b0) begin
            n_fail++;
            $display("FAIL gap_async_reset vec got %b want %b", vec, V_RESET);
        end
        step();
        async_rst_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_release();
        test_clk_en();
        test_timeout();
        test_request_run();
        test_request_disabled();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end
endmodule
